gray_conv_arbiter: RTL and testbench

Round-robin arbiter that shares one binary-to-Gray conversion unit between `N_REQ` requesters. Each requester presents a binary value with a request. The block grants one requester per cycle, converts its value to Gray code (G = B ^ (B >> 1)), and holds the result in a single-entry output register drained by a valid/ready handshake. It sits between the counter/pointer sources and any consumer needing Gray-encoded values, such as CDC pointer logic.

---
 rtl/gray_arb_pkg.sv | 21 ++
 rtl/binary_to_gray_n.sv | 12 +
 rtl/gray_conv_arbiter.sv | 120 ++++++++++++
 tb/tb_gray_conv_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_arb_pkg.sv
// Shared definitions for the round-robin arbiter that feeds a single
// binary-to-Gray converter: default sizing, output-stage state encoding
// and a reference conversion helper for the default width.
package gray_arb_pkg;

    localparam int N_REQ_DEFAULT = 4;
    localparam int WIDTH_DEFAULT = 4;
    localparam int ID_W          = $clog2(N_REQ_DEFAULT);

    // Output register occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Gray encoding: each bit is the XOR of itself and the next more significant bit.
    function automatic logic [WIDTH_DEFAULT-1:0] bin2gray(input logic [WIDTH_DEFAULT-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/binary_to_gray_n.sv
// Purely combinational binary-to-Gray converter of parameterised width.
// The MSB passes straight through; every lower bit is B[k+1] ^ B[k].
module binary_to_gray_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter between N_REQ
// requesters, with a single-entry output register.
//
// Handshakes:
//   req/ack   : requester i holds req[i] (with stable bin_in slice) until it
//               sees ack[i]; ack is one-hot, combinational, and marks the cycle
//               in which that requester's value is captured on the next edge.
//   out_valid/out_ready : a value transfers on any rising edge where both are
//               high; out_gray/out_id stay stable while out_valid && !out_ready.
//
// The output register may be reloaded in the same cycle it drains, so a
// continuous stream sustains one conversion per cycle.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] bin_in,
    output logic [N_REQ-1:0]       ack,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_gray,
    output logic [ID_W-1:0]        out_id
);

    out_state_t        state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   winner;
    logic              grant_found;
    logic              load_ok;
    logic              do_grant;
    logic [WIDTH-1:0]  win_bin;
    logic [WIDTH-1:0]  win_gray;

    assign out_valid = (state == FULL);

    // The register can take a new value when it is empty or draining this cycle.
    assign load_ok  = !out_valid || out_ready;
    assign do_grant = grant_found && load_ok && rst_n;

    // Rotate-and-priority-encode: search starts one past the last winner.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx         = 0;
        cand        = '0;
        grant_found = 1'b0;
        winner      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx  = (int'(last_grant) + off) % N_REQ;
            cand = ID_W'(idx);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                winner      = cand;
            end
        end
    end

    // One-hot acknowledge for the winner, only when the capture actually happens.
    always_comb begin
        ack = '0;
        if (do_grant) begin
            ack[winner] = 1'b1;
        end
    end

    // Select the winner's binary value for the shared converter.
    always_comb begin
        win_bin = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                win_bin = bin_in[i*WIDTH +: WIDTH];
            end
        end
    end

    binary_to_gray_n #(
        .WIDTH (WIDTH)
    ) u_conv (
        .bin  (win_bin),
        .gray (win_gray)
    );

    // Output-stage FSM: load on grant, empty on drain without grant, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_gray   <= '0;
            out_id     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                EMPTY: begin
                    if (do_grant) begin
                        state      <= FULL;
                        out_gray   <= win_gray;
                        out_id     <= winner;
                        last_grant <= winner;
                    end
                end
                FULL: begin
                    if (do_grant) begin
                        out_gray   <= win_gray;
                        out_id     <= winner;
                        last_grant <= winner;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter (N_REQ=4, WIDTH=4). Inputs change on
// the falling edge; ack and the registered outputs are sampled 1ns later.
module tb_gray_conv_arbiter;

    logic                              clk;
    logic                              rst_n;
    logic [3:0]                        req;
    logic [15:0]                       bin_in;
    logic [3:0]                        ack;
    logic                              out_valid;
    logic                              out_ready;
    logic [3:0]                        out_gray;
    logic [gray_arb_pkg::ID_W-1:0]     out_id;

    int tests;
    int fails;

    // Hand-written Gray codes for B = 0..15.
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_conv_arbiter #(
        .N_REQ (4),
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bin_in    (bin_in),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req       = 4'(  $urandom_range(0, 15));
        bin_in    = 16'($urandom);
        out_ready = 1'($urandom_range(0, 1));

        // ---- Reset with random inputs ----
        repeat (3) begin
            @(negedge clk);
            req    = 4'($urandom_range(0, 15));
            bin_in = 16'($urandom);
        end
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_gray",  32'(out_gray),  32'd0);
        chk("rst_id",    32'(out_id),    32'd0);
        chk("rst_ack",   32'(ack),       32'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b1;

        // ---- First transaction latency ----
        @(negedge clk);
        req          = 4'b0001;
        bin_in[3:0]  = 4'b0110;
        #1;
        chk("first_ack",   32'(ack),       32'b0001);
        chk("first_empty", 32'(out_valid), 32'd0);
        @(negedge clk);
        req = 4'b0000;
        #1;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_gray",  32'(out_gray),  32'b0101);
        chk("first_id",    32'(out_id),    32'd0);
        chk("first_noack", 32'(ack),       32'd0);

        // ---- Round-robin from a fresh reset ----
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bin_in = 16'h3210;
        req    = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                req[i-1] = 1'b0;
            end
            #1;
            chk("rr_ack", 32'(ack), 32'(1 << i));
            if (i > 0) begin
                chk("rr_valid", 32'(out_valid), 32'd1);
                chk("rr_gray",  32'(out_gray),  32'(gray_tab[i-1]));
                chk("rr_id",    32'(out_id),    32'(i - 1));
            end
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        chk("rr_last_gray", 32'(out_gray), 32'b0010);
        chk("rr_last_id",   32'(out_id),   32'd3);
        chk("rr_idle_ack",  32'(ack),      32'd0);

        // ---- Backpressure: FULL with 0011 from requester 2 ----
        @(negedge clk);
        req          = 4'b0100;
        bin_in[11:8] = 4'b0010;
        #1;
        chk("bp_load_ack", 32'(ack), 32'b0100);
        @(negedge clk);
        req         = 4'b0001;
        bin_in[3:0] = 4'b0101;
        out_ready   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ack",   32'(ack),       32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_gray",  32'(out_gray),  32'b0011);
            chk("bp_id",    32'(out_id),    32'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ack", 32'(ack),      32'b0001);
        chk("bp_release_gry", 32'(out_gray), 32'b0011);
        @(negedge clk);
        req = 4'b0000;
        #1;
        chk("bp_reload_valid", 32'(out_valid), 32'd1);
        chk("bp_reload_gray",  32'(out_gray),  32'b0111);
        chk("bp_reload_id",    32'(out_id),    32'd0);

        // ---- Wrap-around: make 3 the last grant, then req=1001 ----
        @(negedge clk);
        req            = 4'b1000;
        bin_in[15:12]  = 4'b1000;
        #1;
        chk("wrap_pre_ack", 32'(ack), 32'b1000);
        @(negedge clk);
        req           = 4'b1001;
        bin_in[15:12] = 4'b1111;
        bin_in[3:0]   = 4'b0011;
        #1;
        chk("wrap_ack0", 32'(ack),      32'b0001);
        chk("wrap_gry3", 32'(out_gray), 32'b1100);
        chk("wrap_id3",  32'(out_id),   32'd3);
        @(negedge clk);
        req = 4'b1000;
        #1;
        chk("wrap_ack3", 32'(ack),      32'b1000);
        chk("wrap_gry0", 32'(out_gray), 32'b0010);
        chk("wrap_id0",  32'(out_id),   32'd0);
        @(negedge clk);
        req = 4'b0000;
        #1;
        chk("wrap_gry3b", 32'(out_gray), 32'b1000);
        chk("wrap_id3b",  32'(out_id),   32'd3);
        @(negedge clk);
        #1;
        chk("drain_valid",     32'(out_valid), 32'd0);
        chk("drain_hold_gray", 32'(out_gray),  32'b1000);
        chk("drain_hold_id",   32'(out_id),    32'd3);

        // ---- Exhaustive conversion through requester 2 ----
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            req          = 4'b0100;
            bin_in[11:8] = 4'(b);
            #1;
            chk("sweep_ack", 32'(ack), 32'b0100);
            if (b > 0) begin
                chk("sweep_gray", 32'(out_gray), 32'(gray_tab[b-1]));
                chk("sweep_id",   32'(out_id),   32'd2);
            end
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        chk("sweep_gray_last", 32'(out_gray), 32'b1000);
        chk("sweep_id_last",   32'(out_id),   32'd2);

        // ---- Asynchronous reset while FULL with requests pending ----
        @(negedge clk);
        req         = 4'b0010;
        bin_in[7:4] = 4'b1010;
        #1;
        chk("mid_load_ack", 32'(ack), 32'b0010);
        @(negedge clk);
        req       = 4'b1111;
        out_ready = 1'b0;
        #1;
        chk("mid_full_gray", 32'(out_gray),  32'b1111);
        chk("mid_full_ack",  32'(ack),       32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_gray",  32'(out_gray),  32'd0);
        chk("mid_rst_id",    32'(out_id),    32'd0);
        chk("mid_rst_ack",   32'(ack),       32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ack", 32'(ack), 32'b0001);
        @(negedge clk);
        req = 4'b0000;
        #1;
        chk("post_rst_gray", 32'(out_gray), 32'b0010);
        chk("post_rst_id",   32'(out_id),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
